// File: rtl/echo_fifo_pkg.sv
// Shared constants and helpers for the echo_fifo loopback buffer.
// ASCII bounds feed the optional case-swap path (ECHO_FIFO_CASE_SWAP_EN).
package echo_fifo_pkg;

    localparam logic [7:0] UC_LO    = 8'h41;
    localparam logic [7:0] UC_HI    = 8'h5A;
    localparam logic [7:0] LC_LO    = 8'h61;
    localparam logic [7:0] LC_HI    = 8'h7A;
    localparam logic [7:0] CASE_BIT = 8'h20;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic is_alpha(input logic [7:0] b);
        logic hit;
        if (((b >= UC_LO) && (b <= UC_HI)) || ((b >= LC_LO) && (b <= LC_HI))) begin
            hit = 1'b1;
        end else begin
            hit = 1'b0;
        end
        return hit;
    endfunction

    // Letters get bit 5 flipped; everything else passes through untouched.
    function automatic logic [7:0] case_swap(input logic [7:0] b);
        logic [7:0] r;
        if (is_alpha(b)) begin
            r = b ^ CASE_BIT;
        end else begin
            r = b;
        end
        return r;
    endfunction

endpackage

// File: rtl/echo_fifo_mem.sv
// DEPTH x 8 register file: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module echo_fifo_mem
    import echo_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];

    // Storage write port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/echo_fifo.sv
// Byte loopback FIFO between the CDC OUT and IN streams with valid/ready on both sides.
// Optional ASCII case swap on push when ECHO_FIFO_CASE_SWAP_EN is defined.
module echo_fifo
    import echo_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [7:0]             rx_data_i,
    input  logic                   rx_valid_i,
    output logic                   rx_ready_o,
    output logic [7:0]             tx_data_o,
    output logic                   tx_valid_o,
    input  logic                   tx_ready_i,
    output logic [$clog2(DEPTH):0] level_o,
    output logic [CNT_W-1:0]       tx_count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] tx_count_q, tx_count_d;
    logic             empty_s;
    logic             full_s;
    logic             push_s;
    logic             pop_s;
    logic [7:0]       wdata_s;

    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign full_s  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                     (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]);
    assign push_s  = rx_valid_i && !full_s;
    assign pop_s   = tx_ready_i && !empty_s;

`ifdef ECHO_FIFO_CASE_SWAP_EN
    assign wdata_s = case_swap(rx_data_i);
`else
    assign wdata_s = rx_data_i;
`endif

    // Next-state for pointers and returned-byte counter.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        tx_count_d = tx_count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d   = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
            tx_count_d = tx_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d   = rd_ptr_q;
            tx_count_d = tx_count_q;
        end
    end

    // State registers; reset wins over any pop in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            tx_count_q <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tx_count_q <= tx_count_d;
        end
    end

    echo_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (push_s),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (wdata_s),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (tx_data_o)
    );

    assign rx_ready_o = !full_s;
    assign tx_valid_o = !empty_s;
    assign level_o    = wr_ptr_q - rd_ptr_q;
    assign tx_count_o = tx_count_q;

endmodule

// File: tb/tb_echo_fifo.sv
// Directed self-checking bench for echo_fifo (DEPTH=16, CNT_W=16).
module tb_echo_fifo;

    logic        clk;
    logic        rst_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [4:0]  level_o;
    logic [15:0] tx_count_o;

    int tests;
    int fails;

    echo_fifo #(.DEPTH(16), .CNT_W(16)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
        .rx_ready_o (rx_ready_o),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i),
        .level_o    (level_o),
        .tx_count_o (tx_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] swap_exp [3];
        logic [7:0] swap_in  [3];
        tests = 0;
        fails = 0;
        rst_i = 1'b1;
        rx_valid_i = 1'b0;
        rx_data_i = 8'h00;
        tx_ready_i = 1'b0;
        step();
        step();
        rst_i = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            chk("idle_rx_ready", {31'd0, rx_ready_o}, 32'd1);
            chk("idle_tx_valid", {31'd0, tx_valid_o}, 32'd0);
            chk("idle_level", {27'd0, level_o}, 32'd0);
            chk("idle_count", {16'd0, tx_count_o}, 32'd0);
            step();
        end

        // Push 31,32,33 with tx blocked
        for (int i = 0; i < 3; i++) begin
            rx_valid_i = 1'b1;
            rx_data_i = 8'h31 + 8'(i);
            step();
            chk("push3_level", {27'd0, level_o}, 32'(i + 1));
            chk("push3_tx_valid", {31'd0, tx_valid_o}, 32'd1);
            chk("push3_head", {24'd0, tx_data_o}, 32'h31);
        end
        rx_valid_i = 1'b0;
        tx_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("pop3_valid", {31'd0, tx_valid_o}, 32'd1);
            chk("pop3_data", {24'd0, tx_data_o}, 32'h31 + 32'(i));
            step();
        end
        tx_ready_i = 1'b0;
        chk("pop3_count", {16'd0, tx_count_o}, 32'd3);
        chk("pop3_level", {27'd0, level_o}, 32'd0);
        chk("pop3_empty", {31'd0, tx_valid_o}, 32'd0);

        // Fill to DEPTH
        for (int i = 0; i < 16; i++) begin
            chk("fill_ready", {31'd0, rx_ready_o}, 32'd1);
            rx_valid_i = 1'b1;
            rx_data_i = 8'(i);
            step();
        end
        chk("full_level", {27'd0, level_o}, 32'd16);
        chk("full_ready", {31'd0, rx_ready_o}, 32'd0);
        rx_data_i = 8'h10;
        step();
        chk("full_hold_level", {27'd0, level_o}, 32'd16);
        chk("full_hold_ready", {31'd0, rx_ready_o}, 32'd0);
        // Pop while full: no push this cycle
        tx_ready_i = 1'b1;
        chk("full_pop_data", {24'd0, tx_data_o}, 32'h00);
        step();
        tx_ready_i = 1'b0;
        chk("after_pop_level", {27'd0, level_o}, 32'd15);
        chk("after_pop_ready", {31'd0, rx_ready_o}, 32'd1);
        step();
        rx_valid_i = 1'b0;
        chk("17th_level", {27'd0, level_o}, 32'd16);
        chk("17th_ready", {31'd0, rx_ready_o}, 32'd0);
        tx_ready_i = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk("drain_valid", {31'd0, tx_valid_o}, 32'd1);
            chk("drain_data", {24'd0, tx_data_o}, 32'(i));
            step();
        end
        tx_ready_i = 1'b0;
        chk("drain_level", {27'd0, level_o}, 32'd0);
        chk("drain_count", {16'd0, tx_count_o}, 32'd20);

        // Level 5, then 100 cycles of simultaneous push/pop
        for (int i = 0; i < 5; i++) begin
            rx_valid_i = 1'b1;
            rx_data_i = 8'h80 + 8'(i);
            step();
        end
        chk("l5_level", {27'd0, level_o}, 32'd5);
        tx_ready_i = 1'b1;
        for (int i = 0; i < 100; i++) begin
            rx_data_i = 8'h85 + 8'(i);
            chk("pp_data", {24'd0, tx_data_o}, 32'h80 + 32'(i));
            step();
            chk("pp_level", {27'd0, level_o}, 32'd5);
        end
        rx_valid_i = 1'b0;
        tx_ready_i = 1'b0;
        chk("pp_count", {16'd0, tx_count_o}, 32'd120);
        chk("pp_head", {24'd0, tx_data_o}, 32'he4);

        // Reach level 7, then reset during a pop
        for (int i = 0; i < 2; i++) begin
            rx_valid_i = 1'b1;
            rx_data_i = 8'he9 + 8'(i);
            step();
        end
        rx_valid_i = 1'b0;
        chk("l7_level", {27'd0, level_o}, 32'd7);
        tx_ready_i = 1'b1;
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        tx_ready_i = 1'b0;
        chk("rst_level", {27'd0, level_o}, 32'd0);
        chk("rst_tx_valid", {31'd0, tx_valid_o}, 32'd0);
        chk("rst_count", {16'd0, tx_count_o}, 32'd0);
        chk("rst_rx_ready", {31'd0, rx_ready_o}, 32'd1);

        // Case-swap behaviour (or plain passthrough)
        swap_in[0] = 8'h61;
        swap_in[1] = 8'h5a;
        swap_in[2] = 8'h39;
`ifdef ECHO_FIFO_CASE_SWAP_EN
        swap_exp[0] = 8'h41;
        swap_exp[1] = 8'h7a;
        swap_exp[2] = 8'h39;
`else
        swap_exp[0] = 8'h61;
        swap_exp[1] = 8'h5a;
        swap_exp[2] = 8'h39;
`endif
        for (int i = 0; i < 3; i++) begin
            rx_valid_i = 1'b1;
            rx_data_i = swap_in[i];
            step();
        end
        rx_valid_i = 1'b0;
        tx_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("swap_valid", {31'd0, tx_valid_o}, 32'd1);
            chk("swap_data", {24'd0, tx_data_o}, {24'd0, swap_exp[i]});
            step();
        end
        tx_ready_i = 1'b0;
        chk("swap_count", {16'd0, tx_count_o}, 32'd3);
        chk("swap_empty", {31'd0, tx_valid_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
